// File: rtl/fifo_flow_controller.sv
// Handshake controller for the parallel-write/parallel-read FIFO datapath:
// turns valid/ready into datapath strobes, keeps a registered output word,
// tracks occupancy and clears the datapath pointers after reset.
module fifo_flow_controller #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned PAR_READ   = 1,
  parameter int unsigned AF_THRESH  = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wvalid,
  output logic                           wready,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH*PAR_READ-1:0] rdata,
  input  logic                           dp_empty,
  input  logic                           dp_full,
  input  logic [DATA_WIDTH*PAR_READ-1:0] dp_data_out,
  output logic                           dp_wbuff,
  output logic                           dp_enr,
  output logic                           dp_clr,
  output logic [ADDR_WIDTH+1:0]          level,
  output logic                           almost_full
);

  localparam int unsigned LW        = ADDR_WIDTH + 2;
  localparam int unsigned LEVEL_MAX = (1 << ADDR_WIDTH) + PAR_READ;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_EMPTY = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t        state;
  logic          load;
  logic          take;
  logic [LW-1:0] level_inc;
  logic [LW-1:0] level_dec;
  logic [LW-1:0] level_next;

  // Handshake decode, datapath strobes and next occupancy
  always_comb begin
    dp_clr     = (state == S_INIT);
    wready     = (state != S_INIT) && !dp_full;
    dp_wbuff   = wvalid && wready;
    load       = !dp_empty && ((state == S_EMPTY) || ((state == S_VALID) && rready));
    dp_enr     = load;
    take       = rvalid && rready;
    level_inc  = dp_wbuff ? LW'(PAR_WRITE) : LW'(0);
    level_dec  = take ? LW'(PAR_READ) : LW'(0);
    level_next = level + level_inc - level_dec;
  end

  // Output-word FSM, registered read data and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      rvalid      <= 1'b0;
      rdata       <= '0;
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          state  <= S_EMPTY;
          rvalid <= 1'b0;
        end
        S_EMPTY: begin
          if (load) begin
            state  <= S_VALID;
            rvalid <= 1'b1;
          end
        end
        S_VALID: begin
          // A consumed word with nothing behind it empties the output register
          if (rready && !load) begin
            state  <= S_EMPTY;
            rvalid <= 1'b0;
          end
        end
        default: begin
          state  <= S_INIT;
          rvalid <= 1'b0;
        end
      endcase

      if (load) begin
        rdata <= dp_data_out;
      end

      level       <= level_next;
      almost_full <= (level_next >= LW'(AF_THRESH));

      // Occupancy must never underflow or exceed datapath depth plus the output word
      assert (!(take && (level < LW'(PAR_READ))));
      assert (level_next <= LW'(LEVEL_MAX));
    end
  end

endmodule

// File: tb/tb_fifo_flow_controller.sv
// Self-checking bench for fifo_flow_controller: a queue-based datapath model
// plus a scoreboard of accepted-but-undelivered words with acceptance times.
module tb_fifo_flow_controller;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int LW    = AW + 2;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wvalid = 1'b0;
  logic          wready;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic          dp_empty = 1'b1;
  logic          dp_full = 1'b0;
  logic [DW-1:0] dp_data_out = '0;
  logic          dp_wbuff;
  logic          dp_enr;
  logic          dp_clr;
  logic [LW-1:0] level;
  logic          almost_full;

  logic [DW-1:0] wdata = '0;

  fifo_flow_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PAR_WRITE(1), .PAR_READ(1), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wvalid(wvalid), .wready(wready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .dp_empty(dp_empty), .dp_full(dp_full), .dp_data_out(dp_data_out),
    .dp_wbuff(dp_wbuff), .dp_enr(dp_enr), .dp_clr(dp_clr),
    .level(level), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // Datapath model: memory queue with pointer clear, write strobe and read advance
  logic [DW-1:0] dpq[$];
  always @(posedge clk) begin
    if (dp_clr === 1'b1) begin
      dpq.delete();
    end else begin
      if (dp_enr === 1'b1 && dpq.size() > 0) void'(dpq.pop_front());
      if (dp_wbuff === 1'b1 && dpq.size() < DEPTH) dpq.push_back(wdata);
    end
    dp_empty    <= (dpq.size() == 0);
    dp_full     <= (dpq.size() == DEPTH);
    dp_data_out <= (dpq.size() > 0) ? dpq[0] : '0;
  end

  // Reference: words accepted but not yet delivered, with the edge they were accepted on
  logic [DW-1:0] refq[$];
  int            reftq[$];
  int            edge_n = 0;
  bit            init_pending = 1'b0;
  logic          exp_wr = 1'b0;
  int            n_assert = 0;
  int            n_fail = 0;
  int            n_del = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A word reaches the output one edge after it was accepted, at the earliest
  task automatic check_state(input string t);
    logic erv;
    int   dpc;
    erv    = (refq.size() > 0) && (reftq[0] < edge_n);
    dpc    = refq.size() - (erv ? 1 : 0);
    exp_wr = !init_pending && (dpc != DEPTH);
    chk({t, "_rvalid"}, 32'(rvalid), 32'(erv));
    chk({t, "_wready"}, 32'(wready), 32'(exp_wr));
    chk({t, "_level"}, 32'(level), 32'(refq.size()));
    chk({t, "_afull"}, 32'(almost_full), 32'(refq.size() >= AF));
    chk({t, "_clr"}, 32'(dp_clr), 32'(init_pending));
    if (erv) chk({t, "_rdata"}, 32'(rdata), 32'(refq[0]));
  endtask

  // One clock: drive at negedge, sample handshake, update model at posedge, check at negedge
  task automatic cycle(input logic wv, input logic rr, input logic [DW-1:0] wd);
    logic acc;
    logic del;
    wvalid = wv;
    rready = rr;
    wdata  = wd;
    #1;
    acc = wvalid & wready;
    del = rvalid & rready;
    chk("wbuff", 32'(dp_wbuff), 32'(wv & exp_wr));
    if (del) begin
      if (refq.size() == 0) chk("rd_unexpected", 32'(del), 32'(0));
      else chk("rdata_order", 32'(rdata), 32'(refq[0]));
    end
    @(posedge clk);
    edge_n++;
    init_pending = 1'b0;
    if (del && refq.size() > 0) begin
      void'(refq.pop_front());
      void'(reftq.pop_front());
      n_del++;
    end
    if (acc) begin
      refq.push_back(wd);
      reftq.push_back(edge_n);
    end
    @(negedge clk);
    check_state("cyc");
  endtask

  task automatic pulse_reset(input int low_cycles);
    rst_n  = 1'b0;
    wvalid = 1'b0;
    rready = 1'b0;
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_clr", 32'(dp_clr), 32'(1));
    refq.delete();
    reftq.delete();
    repeat (low_cycles) @(negedge clk);
    rst_n        = 1'b1;
    init_pending = 1'b1;
    exp_wr       = 1'b0;
    #1;
    chk("init_clr", 32'(dp_clr), 32'(1));
    chk("init_wready", 32'(wready), 32'(0));
    chk("init_level", 32'(level), 32'(0));
  endtask

  initial begin
    int d0;

    // Reset and the single init cycle
    @(negedge clk);
    pulse_reset(2);
    cycle(1'b1, 1'b0, 16'hDEAD);
    chk("init_done_clr", 32'(dp_clr), 32'(0));
    chk("init_refused", 32'(level), 32'(0));

    // Single word: two-cycle latency then drained
    cycle(1'b1, 1'b1, 16'h1234);
    chk("lat_level1", 32'(level), 32'(1));
    chk("lat_rvalid0", 32'(rvalid), 32'(0));
    cycle(1'b0, 1'b1, 16'h0);
    chk("lat_rvalid1", 32'(rvalid), 32'(1));
    chk("lat_rdata", 32'(rdata), 32'(16'h1234));
    cycle(1'b0, 1'b1, 16'h0);
    chk("lat_level0", 32'(level), 32'(0));

    // Fill with the consumer stalled until writes are refused
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DW'(16'hA000 + i));
    chk("full_level", 32'(level), 32'(DEPTH + 1));
    chk("full_wready", 32'(wready), 32'(0));
    chk("full_afull", 32'(almost_full), 32'(1));
    cycle(1'b1, 1'b0, 16'hBEEF);
    chk("full_hold", 32'(level), 32'(DEPTH + 1));

    // Drain one word per cycle
    d0 = n_del;
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 16'h0);
    chk("drain_count", 32'(n_del - d0), 32'(9));
    chk("drain_rvalid", 32'(rvalid), 32'(0));
    chk("drain_level", 32'(level), 32'(0));

    // Streaming: steady occupancy, no bubbles
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DW'(16'hC000 + i));
    for (int i = 3; i < 15; i++) begin
      cycle(1'b1, 1'b1, DW'(16'hC000 + i));
      chk("stream_level", 32'(level), 32'(2));
      chk("stream_rvalid", 32'(rvalid), 32'(1));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h0);

    // Reset mid-operation with a live output word
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(16'hD000 + i));
    chk("pre_rst_level", 32'(level), 32'(5));
    chk("pre_rst_rvalid", 32'(rvalid), 32'(1));
    pulse_reset(1);
    cycle(1'b1, 1'b0, 16'h5A5A);
    cycle(1'b1, 1'b0, 16'h5A5A);
    cycle(1'b0, 1'b0, 16'h0);
    chk("post_rst_rdata", 32'(rdata), 32'(16'h5A5A));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0);

    // Randomized traffic with varying producer/consumer pressure
    for (int i = 0; i < 600; i++) begin
      logic wv;
      logic rr;
      wv = ($urandom_range(0, 99) < ((i < 300) ? 80 : 40));
      rr = ($urandom_range(0, 99) < ((i < 300) ? 35 : 85));
      cycle(wv, rr, DW'($urandom));
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 16'h0);
    chk("final_level", 32'(level), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
